// File: rtl/instr_router_pkg.sv
// instr_router_pkg: shared target-id/region types and the region hit test for the instruction router
package instr_router_pkg;

    localparam int ROUTER_SLV = 2;
    localparam int REGION_AW  = 64;

    typedef logic [$clog2(ROUTER_SLV+1)-1:0] tgt_id_t;

    typedef struct packed {
        logic [REGION_AW-1:0] base;
        logic [REGION_AW-1:0] size;
        logic                 rebase;
    } region_t;

    localparam tgt_id_t LOCAL_ERR_ID = tgt_id_t'(ROUTER_SLV);

    // One extra bit on both sides so base+size never wraps; a zero size can never hit
    function automatic logic region_hit(input logic [REGION_AW-1:0] addr, input region_t r);
        return ({1'b0, addr} >= {1'b0, r.base}) && ({1'b0, addr} < ({1'b0, r.base} + {1'b0, r.size}));
    endfunction

endpackage

// File: rtl/instr_region_decode.sv
// instr_region_decode: combinational address -> {hit, target, rebased address}; INSTR_ROUTER_DECERR_EN sends misses to the internal error slot
module instr_region_decode
    import instr_router_pkg::*;
#(
    parameter int                                 NUM_SLV       = ROUTER_SLV,
    parameter int                                 ADDR_WIDTH    = 32,
    parameter logic [NUM_SLV-1:0][ADDR_WIDTH-1:0] REGION_BASE   = {32'h0000_0000, 32'h0004_0080},
    parameter logic [NUM_SLV-1:0][ADDR_WIDTH-1:0] REGION_SIZE   = {32'h0010_0000, 32'h0000_0080},
    parameter logic [NUM_SLV-1:0]                 REGION_REBASE = 2'b01,
    parameter int                                 DEFAULT_SLV   = 1,
    localparam int                                TW            = $clog2(NUM_SLV+1)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit,
    output logic [TW-1:0]         sel,
    output logic [ADDR_WIDTH-1:0] tgt_addr
);

    region_t regions [NUM_SLV];

    for (genvar g = 0; g < NUM_SLV; g++) begin : g_rg
        assign regions[g] = '{base: REGION_AW'(REGION_BASE[g]), size: REGION_AW'(REGION_SIZE[g]), rebase: REGION_REBASE[g]};
    end

    // Scan from the top index down so the lowest matching region is the one left standing
    always_comb begin
        hit      = 1'b0;
`ifdef INSTR_ROUTER_DECERR_EN
        sel      = TW'(NUM_SLV);
`else
        sel      = TW'(DEFAULT_SLV);
`endif
        tgt_addr = addr;
        for (int i = NUM_SLV-1; i >= 0; i--) begin
            if (region_hit(REGION_AW'(addr), regions[i])) begin
                hit      = 1'b1;
                sel      = TW'(i);
                tgt_addr = regions[i].rebase ? addr - REGION_BASE[i] : addr;
            end
        end
    end

endmodule

// File: rtl/instr_region_router.sv
// instr_region_router: routes core fetches to region targets, keeps responses in order; INSTR_ROUTER_DECERR_EN answers unmapped fetches with an error
module instr_region_router
    import instr_router_pkg::*;
#(
    parameter int                                 NUM_SLV         = ROUTER_SLV,
    parameter int                                 ADDR_WIDTH      = 32,
    parameter int                                 DATA_WIDTH      = 32,
    parameter int                                 MAX_OUTSTANDING = 2,
    parameter logic [NUM_SLV-1:0][ADDR_WIDTH-1:0] REGION_BASE     = {32'h0000_0000, 32'h0004_0080},
    parameter logic [NUM_SLV-1:0][ADDR_WIDTH-1:0] REGION_SIZE     = {32'h0010_0000, 32'h0000_0080},
    parameter logic [NUM_SLV-1:0]                 REGION_REBASE   = 2'b01,
    parameter int                                 DEFAULT_SLV     = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 core_req_i,
    output logic                                 core_gnt_o,
    input  logic [ADDR_WIDTH-1:0]                core_addr_i,
    output logic                                 core_rvalid_o,
    output logic [DATA_WIDTH-1:0]                core_rdata_o,
    output logic                                 core_err_o,
    output logic [NUM_SLV-1:0]                   slv_req_o,
    input  logic [NUM_SLV-1:0]                   slv_gnt_i,
    output logic [NUM_SLV-1:0][ADDR_WIDTH-1:0]   slv_addr_o,
    input  logic [NUM_SLV-1:0]                   slv_rvalid_i,
    input  logic [NUM_SLV-1:0][DATA_WIDTH-1:0]   slv_rdata_i,
    input  logic [NUM_SLV-1:0]                   slv_err_i,
    output logic                                 stray_rsp_o
);

    localparam int TW = $clog2(NUM_SLV+1);
    localparam int CW = $clog2(MAX_OUTSTANDING+1);
`ifdef INSTR_ROUTER_DECERR_EN
    localparam bit DECERR = 1'b1;
`else
    localparam bit DECERR = 1'b0;
`endif

    logic                  dec_hit, sel_local, issue_ok, gnt_sel, accept;
    logic                  slv_rsp, slv_err, local_rsp, rsp, stray_hit, err_pend;
    logic [TW-1:0]         sel, cur_tgt;
    logic [ADDR_WIDTH-1:0] dec_addr;
    logic [CW-1:0]         out_cnt;
    logic [DATA_WIDTH-1:0] slv_rdata;

    instr_region_decode #(
        .NUM_SLV       (NUM_SLV),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .REGION_BASE   (REGION_BASE),
        .REGION_SIZE   (REGION_SIZE),
        .REGION_REBASE (REGION_REBASE),
        .DEFAULT_SLV   (DEFAULT_SLV)
    ) u_dec (
        .addr     (core_addr_i),
        .hit      (dec_hit),
        .sel      (sel),
        .tgt_addr (dec_addr)
    );

    assign sel_local     = DECERR && !dec_hit;
    assign issue_ok      = !rst_i && (out_cnt < CW'(MAX_OUTSTANDING)) && (out_cnt == '0 || sel == cur_tgt);
    assign core_gnt_o    = issue_ok && core_req_i && gnt_sel;
    assign accept        = core_gnt_o;
    assign local_rsp     = err_pend && out_cnt != '0 && cur_tgt == TW'(NUM_SLV);
    assign rsp           = !rst_i && (slv_rsp || local_rsp);
    assign core_rvalid_o = rsp;
    assign core_rdata_o  = (rsp && slv_rsp) ? slv_rdata : '0;
    assign core_err_o    = rsp && (slv_rsp ? slv_err : 1'b1);

    // Steer request/grant/address to the decoded target and take the response only from the owed target
    always_comb begin
        gnt_sel    = sel_local;
        slv_req_o  = '0;
        slv_addr_o = '0;
        slv_rsp    = 1'b0;
        slv_rdata  = '0;
        slv_err    = 1'b0;
        stray_hit  = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel == TW'(i)) begin
                gnt_sel       = slv_gnt_i[i];
                slv_req_o[i]  = issue_ok && core_req_i;
                slv_addr_o[i] = issue_ok ? dec_addr : '0;
            end
            if (out_cnt != '0 && cur_tgt == TW'(i)) begin
                slv_rsp   = slv_rvalid_i[i];
                slv_rdata = slv_rdata_i[i];
                slv_err   = slv_err_i[i];
            end else begin
                stray_hit = stray_hit || slv_rvalid_i[i];
            end
        end
    end

    // Outstanding count, owning target, one-cycle error responder and sticky stray flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_cnt     <= '0;
            cur_tgt     <= '0;
            err_pend    <= 1'b0;
            stray_rsp_o <= 1'b0;
        end else begin
            out_cnt     <= out_cnt + CW'(accept) - CW'(rsp);
            cur_tgt     <= accept ? sel : cur_tgt;
            err_pend    <= accept && sel_local;
            stray_rsp_o <= stray_rsp_o || stray_hit;
        end
    end

endmodule

// File: tb/tb_instr_region_router.sv
// tb_instr_region_router: directed fetches with a response scoreboard checked by an independent monitor
module tb_instr_region_router;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             core_req_i;
    logic             core_gnt_o;
    logic [31:0]      core_addr_i;
    logic             core_rvalid_o;
    logic [31:0]      core_rdata_o;
    logic             core_err_o;
    logic [1:0]       slv_req_o;
    logic [1:0]       slv_gnt_i;
    logic [1:0][31:0] slv_addr_o;
    logic [1:0]       slv_rvalid_i;
    logic [1:0][31:0] slv_rdata_i;
    logic [1:0]       slv_err_i;
    logic             stray_rsp_o;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t m_e;

    instr_region_router dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .core_req_i    (core_req_i),
        .core_gnt_o    (core_gnt_o),
        .core_addr_i   (core_addr_i),
        .core_rvalid_o (core_rvalid_o),
        .core_rdata_o  (core_rdata_o),
        .core_err_o    (core_err_o),
        .slv_req_o     (slv_req_o),
        .slv_gnt_i     (slv_gnt_i),
        .slv_addr_o    (slv_addr_o),
        .slv_rvalid_i  (slv_rvalid_i),
        .slv_rdata_i   (slv_rdata_i),
        .slv_err_i     (slv_err_i),
        .stray_rsp_o   (stray_rsp_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic idle();
        core_req_i   = 1'b0;
        slv_gnt_i    = '0;
        slv_rvalid_i = '0;
        slv_err_i    = '0;
    endtask

    // Every core response is matched against the oldest expected one
    always @(negedge clk_i) begin
        if (core_rvalid_o) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got rdata %0h err %0b want no response", core_rdata_o, core_err_o);
            end else begin
                m_e = q.pop_front();
                chk("rsp_data", 64'(core_rdata_o), 64'(m_e.d));
                chk("rsp_err", 64'(core_err_o), 64'(m_e.e));
            end
        end
    end

    initial begin
        rst_i       = 1'b1;
        idle();
        core_req_i  = 1'b1;
        core_addr_i = 32'h100;
        slv_gnt_i   = 2'b11;
        slv_rvalid_i = 2'b01;
        slv_rdata_i = '0;
        slv_rdata_i[0] = 32'h77;
        smp();
        chk("rst_gnt", 64'(core_gnt_o), 0);
        chk("rst_req", 64'(slv_req_o), 0);
        chk("rst_addr", 64'(slv_addr_o), 0);
        chk("rst_rvalid", 64'(core_rvalid_o), 0);
        chk("rst_rdata", 64'(core_rdata_o), 0);
        cyc();
        chk("rst_stray", 64'(stray_rsp_o), 0);
        chk("rst_cnt", 64'(dut.out_cnt), 0);
        rst_i = 1'b0;
        idle();
        slv_rdata_i = '0;

        core_req_i  = 1'b1;
        core_addr_i = 32'h0004_0084;
        slv_gnt_i   = 2'b01;
        smp();
        chk("t1_gnt", 64'(core_gnt_o), 1);
        chk("t1_req", 64'(slv_req_o), 64'b01);
        chk("t1_addr0", 64'(slv_addr_o[0]), 64'h4);
        chk("t1_addr1", 64'(slv_addr_o[1]), 0);
        q.push_back('{d: 32'hDEAD, e: 1'b0});
        cyc();
        idle();
        slv_rvalid_i   = 2'b01;
        slv_rdata_i[0] = 32'hDEAD;
        smp();
        chk("t1_cnt_busy", 64'(dut.out_cnt), 1);
        cyc();
        idle();
        smp();
        chk("t1_cnt_idle", 64'(dut.out_cnt), 0);
        chk("rdata_gated", 64'(core_rdata_o), 0);
        cyc();

        core_req_i  = 1'b1;
        core_addr_i = 32'h100;
        slv_gnt_i   = 2'b10;
        smp();
        chk("t2_gnt_a", 64'(core_gnt_o), 1);
        chk("t2_addr1", 64'(slv_addr_o[1]), 64'h100);
        q.push_back('{d: 32'h1111, e: 1'b0});
        cyc();
        core_addr_i = 32'h0004_0080;
        slv_gnt_i   = 2'b01;
        smp();
        chk("t2_hold_gnt", 64'(core_gnt_o), 0);
        chk("t2_hold_req", 64'(slv_req_o), 0);
        cyc();
        slv_rvalid_i   = 2'b10;
        slv_rdata_i[1] = 32'h1111;
        smp();
        chk("t2_hold_rsp_cycle", 64'(core_gnt_o), 0);
        cyc();
        slv_rvalid_i = '0;
        smp();
        chk("t2_gnt_b", 64'(core_gnt_o), 1);
        chk("t2_req_b", 64'(slv_req_o), 64'b01);
        chk("t2_addr0_b", 64'(slv_addr_o[0]), 0);
        q.push_back('{d: 32'h2222, e: 1'b0});
        cyc();
        idle();
        slv_rvalid_i   = 2'b01;
        slv_rdata_i[0] = 32'h2222;
        cyc();
        idle();

        core_req_i  = 1'b1;
        slv_gnt_i   = 2'b10;
        core_addr_i = 32'h200;
        smp();
        chk("t3_gnt1", 64'(core_gnt_o), 1);
        q.push_back('{d: 32'hA001, e: 1'b0});
        cyc();
        core_addr_i = 32'h204;
        smp();
        chk("t3_gnt2", 64'(core_gnt_o), 1);
        q.push_back('{d: 32'hA002, e: 1'b0});
        cyc();
        core_addr_i = 32'h208;
        smp();
        chk("t3_stall_gnt", 64'(core_gnt_o), 0);
        chk("t3_stall_req", 64'(slv_req_o), 0);
        chk("t3_cnt_full", 64'(dut.out_cnt), 2);
        cyc();
        slv_rvalid_i   = 2'b10;
        slv_rdata_i[1] = 32'hA001;
        smp();
        chk("t3_full_rsp_gnt", 64'(core_gnt_o), 0);
        cyc();
        slv_rdata_i[1] = 32'hA002;
        smp();
        chk("t3_overlap_gnt", 64'(core_gnt_o), 1);
        chk("t3_cnt_before", 64'(dut.out_cnt), 1);
        q.push_back('{d: 32'hA003, e: 1'b0});
        cyc();
        core_req_i     = 1'b0;
        slv_gnt_i      = '0;
        slv_rdata_i[1] = 32'hA003;
        smp();
        chk("t3_cnt_kept", 64'(dut.out_cnt), 1);
        cyc();
        idle();
        smp();
        chk("t3_cnt_drained", 64'(dut.out_cnt), 0);
        cyc();

        core_req_i  = 1'b1;
        core_addr_i = 32'h0020_0000;
        slv_gnt_i   = 2'b10;
        smp();
        chk("t4_gnt", 64'(core_gnt_o), 1);
`ifdef INSTR_ROUTER_DECERR_EN
        chk("t4_req", 64'(slv_req_o), 0);
        q.push_back('{d: 32'h0, e: 1'b1});
        cyc();
        idle();
        slv_rdata_i[1] = 32'hBEEF;
        smp();
        chk("t4_cnt", 64'(dut.out_cnt), 1);
        cyc();
`else
        chk("t4_req", 64'(slv_req_o), 64'b10);
        chk("t4_addr1", 64'(slv_addr_o[1]), 64'h0020_0000);
        q.push_back('{d: 32'hBAD0, e: 1'b1});
        cyc();
        idle();
        slv_rvalid_i   = 2'b10;
        slv_rdata_i[1] = 32'hBAD0;
        slv_err_i      = 2'b10;
        smp();
        chk("t4_cnt", 64'(dut.out_cnt), 1);
        cyc();
`endif
        idle();
        smp();
        chk("t4_cnt_idle", 64'(dut.out_cnt), 0);
        cyc();

        slv_rvalid_i   = 2'b01;
        slv_rdata_i[0] = 32'h5555;
        smp();
        chk("t5_no_rvalid", 64'(core_rvalid_o), 0);
        chk("t5_stray_before", 64'(stray_rsp_o), 0);
        cyc();
        idle();
        smp();
        chk("t5_stray", 64'(stray_rsp_o), 1);
        repeat (3) cyc();
        smp();
        chk("t5_stray_sticky", 64'(stray_rsp_o), 1);

        cyc();
        core_req_i  = 1'b1;
        slv_gnt_i   = 2'b10;
        core_addr_i = 32'h300;
        cyc();
        core_addr_i = 32'h304;
        cyc();
        idle();
        smp();
        chk("t6_cnt_two", 64'(dut.out_cnt), 2);
        rst_i       = 1'b1;
        core_req_i  = 1'b1;
        core_addr_i = 32'h0004_0084;
        slv_gnt_i   = 2'b11;
        #1;
        chk("t6_rst_gnt", 64'(core_gnt_o), 0);
        chk("t6_rst_req", 64'(slv_req_o), 0);
        chk("t6_rst_addr", 64'(slv_addr_o), 0);
        cyc();
        rst_i = 1'b0;
        idle();
        smp();
        chk("t6_cnt_rst", 64'(dut.out_cnt), 0);
        chk("t6_stray_rst", 64'(stray_rsp_o), 0);
        core_req_i  = 1'b1;
        core_addr_i = 32'h0004_0090;
        slv_gnt_i   = 2'b01;
        #1;
        chk("t6_gnt_after", 64'(core_gnt_o), 1);
        chk("t6_addr0_after", 64'(slv_addr_o[0]), 64'h10);
        q.push_back('{d: 32'hC0DE, e: 1'b0});
        cyc();
        idle();
        slv_rvalid_i   = 2'b11;
        slv_rdata_i[0] = 32'hC0DE;
        slv_rdata_i[1] = 32'hDEAD1;
        smp();
        cyc();
        idle();
        smp();
        chk("t6_late_stray", 64'(stray_rsp_o), 1);
        chk("t6_cnt_end", 64'(dut.out_cnt), 0);
        cyc();
        chk("queue_empty", 64'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
